// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-based in-order fetch queue
module fetch_unit #(
    parameter int               XLEN      = 32,
    parameter int               ILEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               DEPTH     = 2,
    parameter logic [ILEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   q_head, q_tail;
    logic [XLEN-1:0] pf_pc   [DEPTH];
    logic [PW-1:0]   pf_head, pf_tail;
    logic [CW-1:0]   count, outstanding, drop_cnt;

    logic            accept, pop, q_wr, rsp_drop;
    logic [CW:0]     credits_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both buffered and in-flight entries, so a returning response always has a slot.
    always_comb begin
        credits_used   = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = !redirect_valid && (credits_used < DEPTH_C);
        imem_req_addr  = pc & ALIGN_MASK;
        accept         = imem_req_valid && imem_req_ready;
        rsp_drop       = redirect_valid || (drop_cnt != '0);
        q_wr           = imem_rsp_valid && !rsp_drop;
        if_valid       = (count != '0);
        pop            = if_valid && !stall && !redirect_valid;
        if_pc          = if_valid ? q_pc[q_head] : '0;
        if_instr       = if_valid ? q_instr[q_head] : NOP_INSTR;
    end

    // Control state: pc, queue pointers and the in-flight/drop counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
        end else begin
            // The PC FIFO mirrors every in-flight request, stale ones included.
            if (accept)
                pf_tail <= ptr_inc(pf_tail);
            if (imem_rsp_valid)
                pf_head <= ptr_inc(pf_head);
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                pc       <= redirect_pc & ALIGN_MASK;
                count    <= '0;
                q_head   <= '0;
                q_tail   <= '0;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept)
                    pc <= pc + XLEN'(4);
                if (imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (q_wr)
                    q_tail <= ptr_inc(q_tail);
                if (pop)
                    q_head <= ptr_inc(q_head);
                count <= count + CW'(q_wr) - CW'(pop);
            end
        end
    end

    // Data storage needs no reset; validity is carried by the counters and pointers.
    always_ff @(posedge clk) begin
        if (accept)
            pf_pc[pf_tail] <= imem_req_addr;
        if (q_wr) begin
            q_pc[q_tail]    <= pf_pc[pf_head];
            q_instr[q_tail] <= imem_rsp_data;
        end
    end

    // Credit invariants: the queue can never overflow and drops never exceed in-flight requests.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(q_wr && !pop && (count == CW'(DEPTH))));
            assert (drop_cnt <= outstanding);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory, stalls, redirects and resets
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] XORK     = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 1600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat_max  = 0;
    int          pops     = 0;
    bit          tput_phase = 0;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;
    logic [31:0] req_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A new instruction stream starts at the aligned target: expected deliveries and requests restart there.
    function automatic void restart(input logic [31:0] p);
        exp_q.delete();
        gen_pc  = p & ~32'd3;
        req_exp = p & ~32'd3;
    endfunction

    // Stimulus and memory model: inputs change on the falling edge.
    initial begin
        pend_t p;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        restart(RESET_PC);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            rst_n = (c >= 3);
            redirect_valid = 1'b0;
            stall = 1'b0;
            imem_req_ready = 1'b1;
            lat_max = 0;
            tput_phase = 1'b0;
            if (c < 41) begin
                tput_phase = (c >= 8);
            end else if (c < 62) begin
                stall = (c >= 45 && c < 50);
            end else if (c < 90) begin
                lat_max = 2;
                if (c == 70) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; end
                if (c == 80) begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; end
            end else if (c < 100) begin
                imem_req_ready = (c >= 95);
            end else begin
                lat_max = 3;
                imem_req_ready = ($urandom_range(0, 9) < 7);
                stall = ($urandom_range(0, 9) < 3);
                if ($urandom_range(0, 99) < 3) begin
                    redirect_valid = 1'b1;
                    redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
                end
                if ($urandom_range(0, 999) < 4)
                    rst_n = 1'b0;
            end

            if (!rst_n) begin
                pend_q.delete();
                restart(RESET_PC);
            end else if (redirect_valid) begin
                restart(redirect_pc);
            end

            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (rst_n && pend_q.size() > 0 && pend_q[0].due <= c) begin
                p = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = p.addr ^ XORK;
            end

            while (exp_q.size() < 8) begin
                exp_q.push_back(gen_pc);
                gen_pc = gen_pc + 32'd4;
            end
        end
        @(negedge clk);
        checks++;
        if (pops < 200) begin
            failures++;
            $display("FAIL progress: got %0d deliveries expected at least 200", pops);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: samples 2 ns after the falling edge and checks against the scoreboard.
    initial begin
        bit          prev_rst   = 1'b0;
        bit          prev_redir = 1'b0;
        bit          prev_stuck = 1'b0;
        bit          prev_idle  = 1'b0;
        logic [31:0] prev_addr  = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (prev_rst) begin
                chk("reset_if_valid", {31'b0, if_valid}, 32'd0);
                chk("reset_if_instr", if_instr, NOP);
                chk("reset_if_pc", if_pc, 32'd0);
            end
            prev_rst = !rst_n;
            if (!rst_n) begin
                prev_redir = 1'b0; prev_stuck = 1'b0; prev_idle = 1'b0;
                continue;
            end
            if (prev_redir)
                chk("redirect_flush", {31'b0, if_valid}, 32'd0);
            prev_redir = redirect_valid;
            if (redirect_valid) begin
                chk("redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
                prev_stuck = 1'b0; prev_idle = 1'b0;
                continue;
            end

            if (if_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q[0];
                    chk("if_pc", if_pc, e);
                    chk("if_instr", if_instr, e ^ XORK);
                    if (!stall) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end

            if (tput_phase) begin
                if (!if_valid && prev_idle)
                    chk("throughput_gap", 32'd2, 32'd1);
                prev_idle = !if_valid;
            end else begin
                prev_idle = 1'b0;
            end

            if (cyc == 49)
                chk("stall_full_no_req", {31'b0, imem_req_valid}, 32'd0);

            if (prev_stuck) begin
                chk("req_valid_held", {31'b0, imem_req_valid}, 32'd1);
                chk("req_addr_stable", imem_req_addr, prev_addr);
            end

            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, req_exp);
                req_exp = req_exp + 32'd4;
                pend_q.push_back('{addr: imem_req_addr,
                                   due: cyc + 1 + int'($urandom_range(0, lat_max))});
                chk("inflight_limit", pend_q.size(), (pend_q.size() <= DEPTH) ? pend_q.size() : DEPTH);
            end

            prev_stuck = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
        end
    end
endmodule
